// File: rtl/jpeg_zz_pkg.sv
// Shared constants for the zigzag reorder buffer: block geometry, zigzag
// address table and the per-bank occupancy state.
package jpeg_zz_pkg;

   localparam int BLOCK_SIZE = 64;

   // Raster address (row*8+col) of zigzag position k.
   localparam logic [5:0] ZZ [0:63] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FILLING  = 2'd1,
      FULL     = 2'd2,
      DRAINING = 2'd3
   } bank_state_t;

   function automatic logic [5:0] zz_addr(input logic [5:0] k);
      return ZZ[k];
   endfunction

endpackage

// File: rtl/zigzag_reorder_buf_zz_bank.sv
// One 64-coefficient block bank: flop storage with a synchronous write port,
// a combinational read port and the block's bypass mode bit.
module zz_bank #(
   parameter int DATA_W = 12
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [5:0]        waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              bypass_i,
   input  logic [5:0]        raddr_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              bypass_o
);

   logic [DATA_W-1:0] mem_q [64];
   logic              bypass_q;

   // Contents are deliberately not reset; a bank is only read after a full fill.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (we_i && (waddr_i == 6'd0)) begin
         bypass_q <= bypass_i;
      end
   end

   assign rdata_o  = mem_q[raddr_i];
   assign bypass_o = bypass_q;

endmodule

// File: rtl/zigzag_reorder_buf.sv
// Raster-to-zigzag block reorder buffer with 1 or 2 banks and a registered
// valid/ready output stage.  Bank states: EMPTY | free, FILLING | being written,
// FULL | complete, waiting for read, DRAINING | being read or awaiting last handshake.
module zigzag_reorder_buf
   import jpeg_zz_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int NUM_BANKS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_bypass,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [5:0]        out_idx,
   output logic              out_last
);

   localparam int NB_MAX = 2;

   bank_state_t       state_q [NB_MAX];
   bank_state_t       state_d [NB_MAX];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [5:0]        wcnt_q, wcnt_d;
   logic [5:0]        rcnt_q, rcnt_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic [5:0]        out_idx_q, out_idx_d;
   logic              out_last_q, out_last_d;
   logic              out_bank_q, out_bank_d;

   logic [DATA_W-1:0] bank_rdata  [NB_MAX];
   logic              bank_bypass [NB_MAX];
   logic [5:0]        rd_addr;
   logic              wr_fire, wr_done, rd_avail, load, rd_fire;
   bank_state_t       rd_state;

   function automatic logic next_ptr(input logic p);
      return (NUM_BANKS == 1) ? 1'b0 : ~p;
   endfunction

   for (genvar b = 0; b < NB_MAX; b++) begin : g_bank
      if (b < NUM_BANKS) begin : g_used
         zz_bank #(.DATA_W(DATA_W)) u_bank (
            .clk      (clk),
            .we_i     (wr_fire && (wr_ptr_q == 1'(b))),
            .waddr_i  (wcnt_q),
            .wdata_i  (in_data),
            .bypass_i (in_bypass),
            .raddr_i  (rd_addr),
            .rdata_o  (bank_rdata[b]),
            .bypass_o (bank_bypass[b])
         );
      end else begin : g_unused
         assign bank_rdata[b]  = '0;
         assign bank_bypass[b] = 1'b0;
      end
   end

   assign in_ready = (state_q[wr_ptr_q] == EMPTY) || (state_q[wr_ptr_q] == FILLING);
   assign rd_addr  = bank_bypass[rd_ptr_q] ? rcnt_q : zz_addr(rcnt_q);
   assign rd_state = state_q[rd_ptr_q];

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      out_last_d  = out_last_q;
      out_bank_d  = out_bank_q;

      wr_fire = in_valid && in_ready;
      wr_done = wr_fire && (wcnt_q == 6'd63);

      if (wr_fire) begin
         wcnt_d = wcnt_q + 6'd1;
         if (wr_done) begin
            state_d[wr_ptr_q] = FULL;
            wr_ptr_d          = next_ptr(wr_ptr_q);
         end else begin
            state_d[wr_ptr_q] = FILLING;
         end
      end

      // A bank completing its fill this cycle can be read straight away (k=0 is
      // long written), which gives the one-cycle first-output latency.  A
      // DRAINING bank with rcnt back at 0 has issued all reads and only waits
      // for its last handshake.
      rd_avail = (rd_state == FULL)
              || ((rd_state == DRAINING) && (rcnt_q != 6'd0))
              || (wr_done && (wr_ptr_q == rd_ptr_q));
      load     = !out_valid_q || out_ready;
      rd_fire  = rd_avail && load;

      if (out_valid_q && out_ready && out_last_q) begin
         state_d[out_bank_q] = EMPTY;
      end

      if (rd_fire) begin
         state_d[rd_ptr_q] = DRAINING;
         out_valid_d       = 1'b1;
         out_data_d        = bank_rdata[rd_ptr_q];
         out_idx_d         = rcnt_q;
         out_last_d        = (rcnt_q == 6'd63);
         out_bank_d        = rd_ptr_q;
         rcnt_d            = rcnt_q + 6'd1;
         if (rcnt_q == 6'd63) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
         end
      end else if (load) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int b = 0; b < NB_MAX; b++) begin
            state_q[b] <= EMPTY;
         end
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
         out_last_q  <= 1'b0;
         out_bank_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
         out_last_q  <= out_last_d;
         out_bank_q  <= out_bank_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_idx   = out_idx_q;
   assign out_last  = out_last_q;

endmodule
